// File: rtl/spi_lcd_rx_if.sv
// IPIF-style register bus between the bus master and the SPI LCD receiver.
interface spi_lcd_rx_if #(
  parameter int C_NUM_REG    = 2,
  parameter int C_SLV_DWIDTH = 32
);
  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data;
  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE;
  logic [C_NUM_REG-1:0]      Bus2IP_RdCE;
  logic [C_NUM_REG-1:0]      Bus2IP_WrCE;
  logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data;
  logic                      IP2Bus_RdAck;
  logic                      IP2Bus_WrAck;
  logic                      IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/spi_lcd_rx.sv
// SPI mode-0 slave byte receiver for the LCD link; {CD, byte} entries are
// queued in a FIFO read back through the register bus.
module spi_lcd_rx #(
  parameter int C_NUM_REG    = 2,
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_FIFO_DEPTH = 8
) (
  input  logic         Bus2IP_Clk,
  input  logic         Bus2IP_Resetn,
  spi_lcd_rx_if.slave  bus,
  output logic         o_irq,
  input  logic         i_spi_sck,
  input  logic         i_spi_mosi,
  input  logic         i_spi_ss_n,
  input  logic         i_spi_cd
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;

  // [0] first sync stage, [1] synchronised value, [2] previous synchronised value
  logic [2:0] sck_q, sck_d, ss_q, ss_d;
  logic [1:0] mosi_q, mosi_d, cd_q, cd_d;

  logic          en_q, en_d, ie_q, ie_d, irq_q, irq_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdce1_prev_q, rdce1_prev_d;
  logic [8:0]    mem_q [C_FIFO_DEPTH];
  logic [8:0]    mem_d [C_FIFO_DEPTH];

  logic        sck_rise, ss_rise, ss_active;
  logic        reg0_wr, flush, full, empty;
  logic        push_req, push_ok, pop_req;
  logic [8:0]  push_entry;
  logic [31:0] wdata, reg0_word, reg1_word, rd_word;
  logic        unused_wdata;

  assign wdata        = 32'(bus.Bus2IP_Data);
  assign unused_wdata = ^{wdata[31:11], wdata[5:0]};
  assign sck_rise     = sck_q[1] & ~sck_q[2];
  assign ss_rise      = ss_q[1] & ~ss_q[2];
  assign ss_active    = ~ss_q[1];
  assign reg0_wr      = bus.Bus2IP_WrCE[0] & (&bus.Bus2IP_BE);
  assign flush        = reg0_wr & wdata[6];
  assign full         = (count_q == CW'(C_FIFO_DEPTH));
  assign empty        = (count_q == {CW{1'b0}});
  assign pop_req      = bus.Bus2IP_RdCE[1] & ~rdce1_prev_q & ~empty;
  assign push_entry   = {cd_q[1], shreg_q, mosi_q[1]};

  // Next-state logic: synchronisers, frame assembly, FIFO and control flags
  always_comb begin
    sck_d        = {sck_q[1:0], i_spi_sck};
    ss_d         = {ss_q[1:0], i_spi_ss_n};
    mosi_d       = {mosi_q[0], i_spi_mosi};
    cd_d         = {cd_q[0], i_spi_cd};
    en_d         = en_q;
    ie_d         = ie_q;
    irq_d        = irq_q;
    ovr_d        = ovr_q;
    ferr_d       = ferr_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    mem_d        = mem_q;
    rdce1_prev_d = bus.Bus2IP_RdCE[1];
    push_req     = 1'b0;
    push_ok      = 1'b0;

    // Disabling mid-frame silently drops the partial byte
    if (!en_q) begin
      bit_cnt_d = 3'd0;
      shreg_d   = 7'd0;
    end else if (!ss_active) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shreg_d = {shreg_q[5:0], mosi_q[1]};
      if (bit_cnt_q == 3'd7) begin
        push_req  = 1'b1;
        bit_cnt_d = 3'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    if (ss_rise && (bit_cnt_q != 3'd0)) begin
      ferr_d = 1'b1;
    end else begin
      ferr_d = ferr_q;
    end

    if (flush) begin
      count_d  = {CW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
    end else begin
      push_ok = push_req & (~full | pop_req);
      if (push_req && full && !pop_req) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_req) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_req})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (reg0_wr && wdata[8]) begin
      irq_d = 1'b0;
    end else if (push_ok && ie_q) begin
      irq_d = 1'b1;
    end else begin
      irq_d = irq_q;
    end

    if (reg0_wr) begin
      en_d = wdata[10];
      ie_d = wdata[9];
      if (wdata[7]) begin
        ovr_d  = 1'b0;
        ferr_d = 1'b0;
      end else begin
        ovr_d  = ovr_d;
        ferr_d = ferr_d;
      end
    end else begin
      en_d = en_q;
      ie_d = ie_q;
    end
  end

  // State registers
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      sck_q        <= 3'b000;
      ss_q         <= 3'b111;
      mosi_q       <= 2'b00;
      cd_q         <= 2'b00;
      en_q         <= 1'b0;
      ie_q         <= 1'b0;
      irq_q        <= 1'b0;
      ovr_q        <= 1'b0;
      ferr_q       <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 7'd0;
      rd_ptr_q     <= {AW{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      rdce1_prev_q <= 1'b0;
      for (int i = 0; i < C_FIFO_DEPTH; i++) begin
        mem_q[i] <= 9'd0;
      end
    end else begin
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      cd_q         <= cd_d;
      en_q         <= en_d;
      ie_q         <= ie_d;
      irq_q        <= irq_d;
      ovr_q        <= ovr_d;
      ferr_q       <= ferr_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      rdce1_prev_q <= rdce1_prev_d;
      mem_q        <= mem_d;
    end
  end

  // Register read mux; reg1 returns the head before any pop takes effect
  always_comb begin
    reg0_word = {11'd0, 5'(count_q), 4'd0, ferr_q, en_q, ie_q, irq_q, ovr_q,
                 5'd0, full, empty};
    if (empty) begin
      reg1_word = 32'd0;
    end else begin
      reg1_word = {1'b1, 22'd0, mem_q[rd_ptr_q]};
    end
    if (bus.Bus2IP_RdCE[0]) begin
      rd_word = reg0_word;
    end else if (bus.Bus2IP_RdCE[1]) begin
      rd_word = reg1_word;
    end else begin
      rd_word = 32'd0;
    end
  end

  assign bus.IP2Bus_Data  = C_SLV_DWIDTH'(rd_word);
  assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
  assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
  assign bus.IP2Bus_Error = 1'b0;
  assign o_irq            = irq_q;

endmodule
